kmeans_centroid_update_k3_d4: RTL and testbench
===============================================

KMEANS_CENTROID_UPDATE_K3_D4 -- requirements
Module: kmeans_centroid_update_k3_d4

Interface
REQ-001 SHALL have parameter input_data_width, default 16, meaning the unsigned width of each point and centroid coordinate.
REQ-002 SHALL have parameter centroid_id_width, default 2, meaning the width of the centroid index.
REQ-003 SHALL have parameter count_width, default 16, meaning the per-centroid sample counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports centroid{k}_d{d} (k=0..2, d=0..3), input, input_data_width each: current centroids, used for empty clusters.
REQ-007 SHALL have port valid_in, input, 1 bit: sample present this cycle.
REQ-008 SHALL have port ready_in, output, 1 bit: block accepts samples; a sample is taken only when valid_in and ready_in are both high.
REQ-009 SHALL have ports input_data0..3, input, input_data_width each: classified point coordinates.
REQ-010 SHALL have port selected_centroid, input, centroid_id_width: winning centroid index for the sample.
REQ-011 SHALL have port last_in, input, 1 bit: the qualified sample is the final one of the epoch.
REQ-012 SHALL have ports new_centroid{k}_d{d}, output reg, input_data_width each: updated centroids.
REQ-013 SHALL have port done, output reg, 1 bit: one-cycle pulse when the new_centroid outputs are updated.
REQ-014 SHALL have port overflow, output reg, 1 bit: sticky flag for a sample dropped because of count saturation.

Function
REQ-015 SHALL implement FSM states ACC, DIV, DONE; reset enters ACC.
REQ-016 In ACC, ready_in SHALL be 1; in DIV and DONE, ready_in SHALL be 0.
REQ-017 In ACC, an accepted sample with selected_centroid k<3 SHALL add input_data{d} to sum[k][d] and increment cnt[k], both updated on the next edge.
REQ-018 Each sum SHALL be input_data_width+count_width bits wide, unsigned, and SHALL never wrap.
REQ-019 An accepted sample with selected_centroid==3 SHALL be discarded, but its last_in SHALL still be honoured.
REQ-020 If cnt[k] is all-ones, the sample SHALL be dropped, sums and count SHALL hold, and overflow SHALL set.
REQ-021 An accepted sample with last_in=1 SHALL be accumulated, and the FSM SHALL then move to DIV on that same edge.
REQ-022 DIV SHALL compute 12 quotients serially in order k0d0, k0d1, ... k2d3, using one restoring divider; each quotient SHALL take exactly S+1 cycles (1 load cycle plus S iterations), where S = sum width.
REQ-023 Each quotient SHALL be sum[k][d]/cnt[k], truncated to input_data_width, and SHALL be latched internally.
REQ-024 If cnt[k]==0, the quotients for k SHALL take centroid{k}_d{d}, sampled at load, and the timing SHALL be unchanged.
REQ-025 After the 12th quotient, DONE SHALL last exactly one cycle.
REQ-026 During DONE, all new_centroid outputs SHALL update together, done SHALL be 1, and all sums and counts SHALL clear.
REQ-027 The FSM SHALL return from DONE to ACC on the next edge.
REQ-028 done SHALL rise 12*(S+1)+1 cycles after the edge that accepts the last_in sample; with default parameters this is 397 cycles.
REQ-029 overflow SHALL clear only on reset.
REQ-030 valid_in asserted while ready_in=0 SHALL be ignored, with no side effects.

Reset
REQ-031 rst SHALL, asynchronously, clear all sums, counts, new_centroid outputs, done and overflow, and force state ACC.
REQ-032 rst asserted mid-DIV SHALL abort the division, and SHALL leave the outputs at 0 rather than partial results.

Configuration
REQ-033 The macro KMEANS_UPD_ROUND_EN SHALL control rounding of quotients.
REQ-034 With KMEANS_UPD_ROUND_EN defined, the divider SHALL divide (sum + floor(cnt/2)) so quotients round to nearest; the adder SHALL be one bit wider so the addition cannot wrap.
REQ-035 Without KMEANS_UPD_ROUND_EN, quotients SHALL be truncated, and latency SHALL be identical in both builds.

Structure
REQ-036 A shared package kmeans_pkg SHALL hold the FSM state encoding, the constants K=3 and D=4, and the sum-width function.
REQ-037 The divider SHALL be a sub-module kmeans_serial_div with start, dividend, divisor, quotient and busy; it SHALL be parameterised on dividend width.

Verification
REQ-038 The bench SHALL drive 4 samples to k0 with d0 = 10, 20, 30, 40 and last on the 4th; the required response is new_centroid0_d0=25 with done 397 cycles later.
REQ-039 The bench SHALL send no samples to k2 with centroid2_d* = 7; the required response is new_centroid2_d*=7.
REQ-040 The bench SHALL send samples 1 and 2 to k1 with last; the required response is 1 without KMEANS_UPD_ROUND_EN and 2 with it.
REQ-041 The bench SHALL drive valid_in during DIV with selected_centroid=0; the required response is that the next epoch excludes the sample and ready_in=0 throughout DIV.
REQ-042 The bench SHALL drive selected_centroid=3 with last_in=1; the required response is that the sample is ignored, DIV starts, and done follows.
REQ-043 The bench SHALL assert rst at cycle 100 of DIV; the required response is state ACC, outputs 0, no done, and the next epoch computes correctly.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means centroid update block: FSM encoding, problem size,
// and accumulator width helper.
package kmeans_pkg;

    localparam int unsigned K = 3;
    localparam int unsigned D = 4;

    typedef enum logic [1:0] {
        ACC,
        DIV,
        DONE
    } state_t;

    // Accumulators hold up to (2^cnt_w - 1) samples of (2^data_w - 1), so this never wraps.
    function automatic int unsigned sum_width(input int unsigned data_w,
                                              input int unsigned cnt_w);
        return data_w + cnt_w;
    endfunction

endpackage

// File: rtl/kmeans_serial_div.sv
// Restoring serial divider: one load cycle on start, then one quotient bit per cycle
// for dividend_width cycles.
module kmeans_serial_div #(
    parameter int unsigned dividend_width = 32,
    parameter int unsigned divisor_width  = 16,
    parameter int unsigned quotient_width = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [dividend_width-1:0] dividend,
    input  logic [divisor_width-1:0]  divisor,
    output logic [quotient_width-1:0] quotient,
    output logic                      busy
);

    localparam int unsigned IterW = $clog2(dividend_width + 1);

    logic [dividend_width-1:0] q_q;
    logic [divisor_width-1:0]  rem_q;
    logic [divisor_width-1:0]  dvs_q;
    logic [IterW-1:0]          iter_q;
    logic [divisor_width:0]    trial;
    logic                      take;

    // Remainder stays below the divisor, so the shifted trial fits in one extra bit.
    always_comb begin
        trial = {rem_q, q_q[dividend_width-1]};
        take  = (trial >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
        end else if (start) begin
            q_q    <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            iter_q <= IterW'(dividend_width);
        end else if (iter_q != '0) begin
            iter_q <= iter_q - IterW'(1);
            q_q    <= {q_q[dividend_width-2:0], take};
            if (take) begin
                rem_q <= divisor_width'(trial - {1'b0, dvs_q});
            end else begin
                rem_q <= trial[divisor_width-1:0];
            end
        end
    end

    assign quotient = q_q[quotient_width-1:0];
    assign busy     = (iter_q != '0);

endmodule

// File: rtl/kmeans_centroid_update_k3_d4.sv
// Accumulates classified points per centroid, then divides serially to produce new centroids.
// Define KMEANS_UPD_ROUND_EN for round-to-nearest quotients (default build truncates).
module kmeans_centroid_update_k3_d4
    import kmeans_pkg::*;
#(
    parameter int unsigned input_data_width  = 16,
    parameter int unsigned centroid_id_width = 2,
    parameter int unsigned count_width       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [input_data_width-1:0]  centroid0_d0,
    input  logic [input_data_width-1:0]  centroid0_d1,
    input  logic [input_data_width-1:0]  centroid0_d2,
    input  logic [input_data_width-1:0]  centroid0_d3,
    input  logic [input_data_width-1:0]  centroid1_d0,
    input  logic [input_data_width-1:0]  centroid1_d1,
    input  logic [input_data_width-1:0]  centroid1_d2,
    input  logic [input_data_width-1:0]  centroid1_d3,
    input  logic [input_data_width-1:0]  centroid2_d0,
    input  logic [input_data_width-1:0]  centroid2_d1,
    input  logic [input_data_width-1:0]  centroid2_d2,
    input  logic [input_data_width-1:0]  centroid2_d3,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [input_data_width-1:0]  input_data0,
    input  logic [input_data_width-1:0]  input_data1,
    input  logic [input_data_width-1:0]  input_data2,
    input  logic [input_data_width-1:0]  input_data3,
    input  logic [centroid_id_width-1:0] selected_centroid,
    input  logic                         last_in,
    output logic [input_data_width-1:0]  new_centroid0_d0,
    output logic [input_data_width-1:0]  new_centroid0_d1,
    output logic [input_data_width-1:0]  new_centroid0_d2,
    output logic [input_data_width-1:0]  new_centroid0_d3,
    output logic [input_data_width-1:0]  new_centroid1_d0,
    output logic [input_data_width-1:0]  new_centroid1_d1,
    output logic [input_data_width-1:0]  new_centroid1_d2,
    output logic [input_data_width-1:0]  new_centroid1_d3,
    output logic [input_data_width-1:0]  new_centroid2_d0,
    output logic [input_data_width-1:0]  new_centroid2_d1,
    output logic [input_data_width-1:0]  new_centroid2_d2,
    output logic [input_data_width-1:0]  new_centroid2_d3,
    output logic                         done,
    output logic                         overflow
);

    localparam int unsigned SumW  = sum_width(input_data_width, count_width);
    localparam int unsigned NumQ  = K * D;
    localparam int unsigned CycW  = $clog2(SumW + 1);
    localparam int unsigned QIdxW = $clog2(NumQ + 1);
    localparam int unsigned KIdxW = $clog2(K);
    localparam int unsigned DIdxW = $clog2(D);

    localparam logic [QIdxW-1:0]             LastQ   = QIdxW'(NumQ);
    localparam logic [CycW-1:0]              LastCyc = CycW'(SumW);
    localparam logic [centroid_id_width-1:0] NumK    = centroid_id_width'(K);

    typedef logic [input_data_width-1:0] coord_t;

    coord_t                 cent   [NumQ];
    coord_t                 din    [D];
    coord_t                 new_q  [NumQ];
    coord_t                 quot_q [NumQ];
    logic [SumW-1:0]        sum_q  [K][D];
    logic [count_width-1:0] cnt_q  [K];

    state_t                 state_q, state_d;
    logic [QIdxW-1:0]       qidx_q;
    logic [CycW-1:0]        cyc_q;
    logic                   done_q;
    logic                   overflow_q;

    logic                   accept;
    logic                   sel_valid;
    logic [KIdxW-1:0]       sel_k;
    logic [KIdxW-1:0]       div_k;
    logic [DIdxW-1:0]       div_d;
    logic                   div_start;
    logic                   div_busy;
    logic [SumW-1:0]        div_base;
    logic [SumW-1:0]        div_dividend;
    logic [count_width-1:0] div_divisor;
    coord_t                 div_quot;

    assign cent[0]  = centroid0_d0;
    assign cent[1]  = centroid0_d1;
    assign cent[2]  = centroid0_d2;
    assign cent[3]  = centroid0_d3;
    assign cent[4]  = centroid1_d0;
    assign cent[5]  = centroid1_d1;
    assign cent[6]  = centroid1_d2;
    assign cent[7]  = centroid1_d3;
    assign cent[8]  = centroid2_d0;
    assign cent[9]  = centroid2_d1;
    assign cent[10] = centroid2_d2;
    assign cent[11] = centroid2_d3;

    assign din[0] = input_data0;
    assign din[1] = input_data1;
    assign din[2] = input_data2;
    assign din[3] = input_data3;

    assign new_centroid0_d0 = new_q[0];
    assign new_centroid0_d1 = new_q[1];
    assign new_centroid0_d2 = new_q[2];
    assign new_centroid0_d3 = new_q[3];
    assign new_centroid1_d0 = new_q[4];
    assign new_centroid1_d1 = new_q[5];
    assign new_centroid1_d2 = new_q[6];
    assign new_centroid1_d3 = new_q[7];
    assign new_centroid2_d0 = new_q[8];
    assign new_centroid2_d1 = new_q[9];
    assign new_centroid2_d2 = new_q[10];
    assign new_centroid2_d3 = new_q[11];

    assign done     = done_q;
    assign overflow = overflow_q;

    assign accept    = valid_in && ready_in;
    assign sel_valid = (selected_centroid < NumK);
    assign sel_k     = KIdxW'(selected_centroid);
    assign div_k     = KIdxW'(qidx_q >> DIdxW);
    assign div_d     = DIdxW'(qidx_q);

    // Each quotient slot is S+1 cycles: cyc_q==0 loads, the remaining S cycles iterate.
    always_comb begin
        state_d   = state_q;
        ready_in  = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ACC: begin
                ready_in = 1'b1;
                if (valid_in && last_in) state_d = DIV;
            end
            DIV: begin
                if (cyc_q == '0 && qidx_q == LastQ) state_d = DONE;
                else if (cyc_q == '0 && !div_busy) div_start = 1'b1;
            end
            DONE:    state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // An empty cluster divides its current centroid by one so its timing matches the others.
    always_comb begin
        div_base    = '0;
        div_divisor = count_width'(1);
        if (qidx_q < LastQ) begin
            if (cnt_q[div_k] != '0) begin
                div_base    = sum_q[div_k][div_d];
                div_divisor = cnt_q[div_k];
            end else begin
                div_base = SumW'(cent[qidx_q]);
            end
        end
    end

`ifdef KMEANS_UPD_ROUND_EN
    logic [SumW:0] div_round;
    assign div_round    = {1'b0, div_base} + (SumW + 1)'(div_divisor >> 1);
    assign div_dividend = div_round[SumW-1:0];
`else
    assign div_dividend = div_base;
`endif

    kmeans_serial_div #(
        .dividend_width (SumW),
        .divisor_width  (count_width),
        .quotient_width (input_data_width)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .busy     (div_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                cnt_q[k] <= '0;
                for (int d = 0; d < D; d++) sum_q[k][d] <= '0;
            end
            for (int i = 0; i < NumQ; i++) begin
                new_q[i]  <= '0;
                quot_q[i] <= '0;
            end
            qidx_q     <= '0;
            cyc_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ACC: begin
                    qidx_q <= '0;
                    cyc_q  <= '0;
                    if (accept && sel_valid) begin
                        if (&cnt_q[sel_k]) begin
                            overflow_q <= 1'b1;
                        end else begin
                            cnt_q[sel_k] <= cnt_q[sel_k] + count_width'(1);
                            for (int d = 0; d < D; d++) begin
                                sum_q[sel_k][d] <= sum_q[sel_k][d] + SumW'(din[d]);
                            end
                        end
                    end
                end
                DIV: begin
                    if (cyc_q == LastCyc) begin
                        cyc_q  <= '0;
                        qidx_q <= qidx_q + QIdxW'(1);
                    end else begin
                        cyc_q <= cyc_q + CycW'(1);
                    end
                    // Previous slot's quotient is final here, just before the divider reloads.
                    if (cyc_q == '0 && qidx_q != '0) begin
                        quot_q[qidx_q - QIdxW'(1)] <= div_quot;
                    end
                    if (cyc_q == '0 && qidx_q == LastQ) begin
                        for (int i = 0; i < NumQ - 1; i++) new_q[i] <= quot_q[i];
                        new_q[NumQ-1] <= div_quot;
                        done_q        <= 1'b1;
                    end
                end
                DONE: begin
                    for (int k = 0; k < K; k++) begin
                        cnt_q[k] <= '0;
                        for (int d = 0; d < D; d++) sum_q[k][d] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d4.sv
// Randomized bench with an epoch-level reference model of the centroid update block.
module tb_kmeans_centroid_update_k3_d4;

    localparam int W   = 16;
    localparam int Lat = 12 * 33 + 1;
`ifdef KMEANS_UPD_ROUND_EN
    localparam bit Round = 1'b1;
`else
    localparam bit Round = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cent [12];
    logic [W-1:0] dout [12];
    logic [W-1:0] din  [4];
    logic         valid_in = 1'b0;
    logic         last_in  = 1'b0;
    logic [1:0]   sel      = 2'd0;
    logic         ready_in, done, overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kmeans_centroid_update_k3_d4 dut (
        .clk               (clk),
        .rst               (rst),
        .centroid0_d0      (cent[0]),
        .centroid0_d1      (cent[1]),
        .centroid0_d2      (cent[2]),
        .centroid0_d3      (cent[3]),
        .centroid1_d0      (cent[4]),
        .centroid1_d1      (cent[5]),
        .centroid1_d2      (cent[6]),
        .centroid1_d3      (cent[7]),
        .centroid2_d0      (cent[8]),
        .centroid2_d1      (cent[9]),
        .centroid2_d2      (cent[10]),
        .centroid2_d3      (cent[11]),
        .valid_in          (valid_in),
        .ready_in          (ready_in),
        .input_data0       (din[0]),
        .input_data1       (din[1]),
        .input_data2       (din[2]),
        .input_data3       (din[3]),
        .selected_centroid (sel),
        .last_in           (last_in),
        .new_centroid0_d0  (dout[0]),
        .new_centroid0_d1  (dout[1]),
        .new_centroid0_d2  (dout[2]),
        .new_centroid0_d3  (dout[3]),
        .new_centroid1_d0  (dout[4]),
        .new_centroid1_d1  (dout[5]),
        .new_centroid1_d2  (dout[6]),
        .new_centroid1_d3  (dout[7]),
        .new_centroid2_d0  (dout[8]),
        .new_centroid2_d1  (dout[9]),
        .new_centroid2_d2  (dout[10]),
        .new_centroid2_d3  (dout[11]),
        .done              (done),
        .overflow          (overflow)
    );

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Reference model: per-epoch sums and counts, results published Lat edges after last.
    longint       msum [3][4];
    int           mcnt [3];
    logic [W-1:0] mout [12];
    logic [W-1:0] pend [12];
    bit           m_busy = 1'b0;
    bit           m_ovf  = 1'b0;
    int           cyc    = 0;
    int           e_edge = 0;

    function automatic logic [W-1:0] mean(input longint s, input int c, input logic [W-1:0] cv);
        longint q;
        if (c == 0) return cv;
        q = (s + (Round ? longint'(c / 2) : 64'd0)) / c;
        return q[W-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            for (int d = 0; d < 4; d++) msum[k][d] = 0;
        end
        for (int i = 0; i < 12; i++) mout[i] = '0;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin : model
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_clear();
            end else begin
                cyc++;
                if (!m_busy) begin
                    if (valid_in) begin
                        if (sel < 2'd3) begin
                            if (mcnt[sel] == 65535) m_ovf = 1'b1;
                            else begin
                                mcnt[sel]++;
                                for (int d = 0; d < 4; d++) msum[sel][d] += din[d];
                            end
                        end
                        if (last_in) begin
                            for (int k = 0; k < 3; k++)
                                for (int d = 0; d < 4; d++)
                                    pend[k*4+d] = mean(msum[k][d], mcnt[k], cent[k*4+d]);
                            for (int k = 0; k < 3; k++) begin
                                mcnt[k] = 0;
                                for (int d = 0; d < 4; d++) msum[k][d] = 0;
                            end
                            m_busy = 1'b1;
                            e_edge = cyc;
                        end
                    end
                end else if (cyc == e_edge + Lat) begin
                    for (int i = 0; i < 12; i++) mout[i] = pend[i];
                end else if (cyc == e_edge + Lat + 1) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ready_in", 0, ready_in, !m_busy);
                chk("done", 0, done, m_busy && (cyc == e_edge + Lat));
                chk("overflow", 0, overflow, m_ovf);
                for (int i = 0; i < 12; i++) chk("new_centroid", i, dout[i], mout[i]);
            end
        end
    end

    task automatic send(input logic [1:0] k, input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [W-1:0] d3, input bit last);
        valid_in = 1'b1;
        sel      = k;
        din[0]   = d0;
        din[1]   = d1;
        din[2]   = d2;
        din[3]   = d3;
        last_in  = last;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 1000);
        chk("done_seen", 0, done, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;
    int seen;

    initial begin : stim
        for (int i = 0; i < 12; i++) cent[i] = W'(100 + i);
        for (int i = 8; i < 12; i++) cent[i] = 16'd7;
        for (int d = 0; d < 4; d++) din[d] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 0, ready_in, 1);
        chk("rst_done", 0, done, 0);
        chk("rst_overflow", 0, overflow, 0);
        for (int i = 0; i < 12; i++) chk("rst_out", i, dout[i], 0);
        step();

        // Epoch 1: k1 gets 1 and 2, k0 gets 10..40 in d0, k2 stays empty.
        send(2'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
        send(2'd1, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
        send(2'd0, 16'd10, 16'd1, 16'd2, 16'd3, 1'b0);
        send(2'd0, 16'd20, 16'd1, 16'd2, 16'd3, 1'b0);
        send(2'd0, 16'd30, 16'd1, 16'd2, 16'd3, 1'b0);
        send(2'd0, 16'd40, 16'd1, 16'd2, 16'd3, 1'b1);
        wait_done(n);
        chk("latency", 1, n, 397);
        chk("k0d0_mean", 0, dout[0], 25);
        chk("k0d1_mean", 0, dout[1], 1);
        for (int d = 0; d < 4; d++) chk("k1_round", d, dout[4+d], Round ? 2 : 1);
        for (int d = 0; d < 4; d++) chk("k2_empty", d, dout[8+d], 7);
        step();

        // Epoch 2: stray samples offered during DIV must be refused.
        send(2'd0, 16'd1000, 16'd0, 16'd0, 16'd0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            valid_in = 1'b1;
            sel      = 2'd0;
            din[0]   = 16'd60000;
            last_in  = 1'($urandom_range(0, 1));
            chk("ready_in_div", i, ready_in, 0);
            step();
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        wait_done(n);
        chk("latency", 2, n, Lat - 60);
        chk("k0d0_single", 0, dout[0], 1000);
        step();

        // Epoch 3: the index-3 sample carries last but contributes nothing.
        send(2'd0, 16'd100, 16'd100, 16'd100, 16'd100, 1'b0);
        send(2'd3, 16'd9999, 16'd9999, 16'd9999, 16'd9999, 1'b1);
        wait_done(n);
        chk("latency", 3, n, Lat);
        chk("k0d0_excl", 0, dout[0], 100);
        step();

        // Epoch 4: reset 100 cycles into the division.
        send(2'd0, 16'd500, 16'd500, 16'd500, 16'd500, 1'b1);
        repeat (100) step();
        rst = 1'b1;
        #2;
        for (int i = 0; i < 12; i++) chk("abort_out", i, dout[i], 0);
        chk("abort_done", 0, done, 0);
        chk("abort_ready", 0, ready_in, 1);
        step();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 450; i++) begin
            step();
            if (done) seen++;
        end
        chk("no_done_after_abort", 0, seen, 0);

        // Epoch 5: clean epoch after the abort.
        send(2'd0, 16'd5, 16'd5, 16'd5, 16'd5, 1'b0);
        send(2'd0, 16'd6, 16'd6, 16'd6, 16'd6, 1'b1);
        wait_done(n);
        chk("latency", 5, n, Lat);
        chk("k0d0_post_abort", 0, dout[0], Round ? 6 : 5);
        chk("k1d0_empty", 0, dout[4], 104);
        step();

        // Random epochs with gaps between samples.
        for (int e = 0; e < 5; e++) begin
            int ns;
            for (int i = 0; i < 12; i++) cent[i] = W'($urandom);
            ns = $urandom_range(1, 24);
            for (int s = 0; s < ns; s++) begin
                repeat ($urandom_range(0, 2)) step();
                send(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom),
                     W'($urandom), s == ns - 1);
            end
            wait_done(n);
            chk("latency_rand", e, n, Lat);
            step();
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
